// File: rtl/zigbee_chip_spreader_if.sv
// Symbol/chip bus of the O-QPSK chip spreader: FIFO side (inData/inEmpty/outReadEnable)
// plus the offset I/Q chip stream toward the modulator.
// Optional macro ZB_SPREADER_SYMCNT_EN adds the 16-bit outSymbolCount signal.
interface zigbee_chip_spreader_if;
  logic [3:0]  inData;
  logic        inEmpty;
  logic        outReadEnable;
  logic [3:0]  outI;
  logic [3:0]  outQ;
  logic        outValid;
  logic        outEndOfSymbol;
  logic        outBusy;
`ifdef ZB_SPREADER_SYMCNT_EN
  logic [15:0] outSymbolCount;
`endif

  // Spreader side: consumes FIFO data, drives the chip stream.
  modport master (
    input  inData,
    input  inEmpty,
`ifdef ZB_SPREADER_SYMCNT_EN
    output outSymbolCount,
`endif
    output outReadEnable,
    output outI,
    output outQ,
    output outValid,
    output outEndOfSymbol,
    output outBusy
  );

  // FIFO / modulator side.
  modport slave (
    output inData,
    output inEmpty,
`ifdef ZB_SPREADER_SYMCNT_EN
    input  outSymbolCount,
`endif
    input  outReadEnable,
    input  outI,
    input  outQ,
    input  outValid,
    input  outEndOfSymbol,
    input  outBusy
  );
endinterface

// File: rtl/zigbee_chip_spreader.sv
// IEEE 802.15.4 transmit chip spreader: pops 4-bit symbols from the input FIFO, maps each
// to its 32-chip PN sequence and drives offset I/Q signed levels (+LEVEL / -LEVEL).
// Even chips go on I, odd chips on Q delayed by one chip period; each chip is held 2*Tc.
// Optional macro ZB_SPREADER_SYMCNT_EN adds a 16-bit count of latched symbols.
// CHIP_DIV must lie in 2..255.
module zigbee_chip_spreader #(
  parameter int CHIP_DIV = 4,
  parameter int LEVEL    = 7
) (
  input  logic inClock,
  input  logic inReset,
  zigbee_chip_spreader_if.master bus
);

  typedef enum logic [1:0] {IDLE, FETCH, SEND, TAIL} stateT;

  // Phase within one I chip (2*Tc), pair index 0..15 gives t = pair*2*CHIP_DIV + phase.
  localparam int PW = $clog2(2 * CHIP_DIV);
  localparam logic [PW-1:0] PHASE_LAST     = PW'(2 * CHIP_DIV - 1);
  localparam logic [PW-1:0] EOS_PHASE      = PW'(2 * CHIP_DIV - 2);
  localparam logic [PW-1:0] PREFETCH_PHASE = PW'(2 * CHIP_DIV - 3);
  localparam logic [PW-1:0] Q_PHASE        = PW'(CHIP_DIV - 1);
  localparam logic [7:0]    TAIL_LAST      = 8'(CHIP_DIV - 1);

  localparam logic [3:0] LEVEL_POS = 4'(LEVEL);
  localparam logic [3:0] LEVEL_NEG = 4'(-LEVEL);

  // Symbol 0 chips, c0 in the MSB.
  localparam logic [31:0] SYM0_CHIPS = 32'b1101_1001_1100_0011_0101_0010_0010_1110;

  stateT          stateReg;
  logic [PW-1:0]  phaseReg;
  logic [3:0]     pairReg;
  logic [7:0]     tailReg;
  logic [3:0]     symReg;
  logic [3:0]     nextSymReg;
  logic           pendingReg;

  // Constant chip ROM: symbol k is symbol 0 rotated right by 4*(k mod 8) chips,
  // and symbols 8..15 additionally invert every odd chip (even bit positions here).
  logic [31:0] chipRom [16];
  genvar gi;
  for (gi = 0; gi < 16; gi++) begin : gRom
    localparam int SHIFT = 4 * (gi % 8);
    localparam logic [63:0] ROTATED  = {SYM0_CHIPS, SYM0_CHIPS} >> SHIFT;
    localparam logic [31:0] ODD_MASK = (gi >= 8) ? 32'h5555_5555 : 32'h0000_0000;
    assign chipRom[gi] = ROTATED[31:0] ^ ODD_MASK;
  end

  // Chip n of a sequence sits at bit 31-n, which is ~n for a 5-bit index.
  logic [4:0] iIdxNext;
  logic [4:0] qIdx;
  logic       iChipNext;
  logic       qChip;
  logic       firstChipFetch;
  logic       firstChipWrap;
  logic       isLastT;

  assign iIdxNext       = {pairReg + 4'd1, 1'b0};
  assign qIdx           = {pairReg, 1'b1};
  assign iChipNext      = chipRom[symReg][~iIdxNext];
  assign qChip          = chipRom[symReg][~qIdx];
  assign firstChipFetch = chipRom[bus.inData][31];
  assign firstChipWrap  = chipRom[nextSymReg][31];
  assign isLastT        = (pairReg == 4'd15) && (phaseReg == PHASE_LAST);

  function automatic logic [3:0] chipLevel(input logic chip);
    return chip ? LEVEL_POS : LEVEL_NEG;
  endfunction

  // Control FSM with registered outputs; output values always describe the cycle after the edge.
  always_ff @(posedge inClock or negedge inReset) begin
    if (!inReset) begin
      stateReg           <= IDLE;
      phaseReg           <= '0;
      pairReg            <= '0;
      tailReg            <= '0;
      symReg             <= '0;
      nextSymReg         <= '0;
      pendingReg         <= 1'b0;
      bus.outReadEnable  <= 1'b0;
      bus.outI           <= '0;
      bus.outQ           <= '0;
      bus.outValid       <= 1'b0;
      bus.outEndOfSymbol <= 1'b0;
      bus.outBusy        <= 1'b0;
    end else begin
      bus.outReadEnable  <= 1'b0;
      bus.outEndOfSymbol <= 1'b0;
      case (stateReg)
        IDLE: begin
          bus.outI     <= '0;
          bus.outQ     <= '0;
          bus.outValid <= 1'b0;
          if (!bus.inEmpty) begin
            stateReg          <= FETCH;
            bus.outReadEnable <= 1'b1;
            bus.outBusy       <= 1'b1;
          end else begin
            bus.outBusy <= 1'b0;
          end
        end

        FETCH: begin
          // Data popped last cycle is on inData now; first chip goes out immediately.
          symReg       <= bus.inData;
          phaseReg     <= '0;
          pairReg      <= '0;
          pendingReg   <= 1'b0;
          stateReg     <= SEND;
          bus.outI     <= chipLevel(firstChipFetch);
          bus.outQ     <= '0;
          bus.outValid <= 1'b1;
          bus.outBusy  <= 1'b1;
        end

        SEND: begin
          // The prefetch pop delivers its data one cycle later; park it until the wrap.
          if (bus.outReadEnable) begin
            nextSymReg <= bus.inData;
          end
          if (isLastT) begin
            if (pendingReg) begin
              // Back-to-back: outQ keeps the previous c31 for the first Tc.
              symReg     <= nextSymReg;
              phaseReg   <= '0;
              pairReg    <= '0;
              pendingReg <= 1'b0;
              bus.outI   <= chipLevel(firstChipWrap);
            end else begin
              stateReg <= TAIL;
              tailReg  <= '0;
              bus.outI <= '0;
            end
          end else begin
            if (phaseReg == PHASE_LAST) begin
              phaseReg <= '0;
              pairReg  <= pairReg + 4'd1;
              bus.outI <= chipLevel(iChipNext);
            end else begin
              phaseReg <= phaseReg + 1'b1;
            end
            if (phaseReg == Q_PHASE) begin
              bus.outQ <= chipLevel(qChip);
            end
            if ((pairReg == 4'd15) && (phaseReg == PREFETCH_PHASE) && !bus.inEmpty) begin
              bus.outReadEnable <= 1'b1;
              pendingReg        <= 1'b1;
            end
            if ((pairReg == 4'd15) && (phaseReg == EOS_PHASE)) begin
              bus.outEndOfSymbol <= 1'b1;
            end
          end
        end

        TAIL: begin
          // Finish the last odd chip on Q for one Tc, then fall silent.
          if (tailReg == TAIL_LAST) begin
            stateReg     <= IDLE;
            bus.outQ     <= '0;
            bus.outValid <= 1'b0;
            bus.outBusy  <= 1'b0;
          end else begin
            tailReg <= tailReg + 8'd1;
          end
        end

        default: begin
          stateReg <= IDLE;
        end
      endcase
    end
  end

`ifdef ZB_SPREADER_SYMCNT_EN
  logic symLatch;
  assign symLatch = (stateReg == FETCH) || ((stateReg == SEND) && isLastT && pendingReg);

  // Count every symbol loaded into the symbol register, wrapping at 16 bits.
  always_ff @(posedge inClock or negedge inReset) begin
    if (!inReset) begin
      bus.outSymbolCount <= '0;
    end else if (symLatch) begin
      bus.outSymbolCount <= bus.outSymbolCount + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_zigbee_chip_spreader.sv
// Self-checking bench for zigbee_chip_spreader: a FIFO model feeds symbols and every
// clock of the chip stream is compared against waveforms computed from the chip rules.
module tb_zigbee_chip_spreader;
  localparam int D     = 4;
  localparam int LV    = 7;
  localparam int SYM_T = 32 * D;
  localparam logic [31:0] BASE = 32'b11011001110000110101001000101110;

  logic inClock = 1'b0;
  logic inReset = 1'b0;

  zigbee_chip_spreader_if bus();

  zigbee_chip_spreader #(.CHIP_DIV(D), .LEVEL(LV)) dut (
    .inClock (inClock),
    .inReset (inReset),
    .bus     (bus)
  );

  always #5 inClock = ~inClock;

  int errors = 0;
  int checks = 0;
  int symCountModel = 0;
  logic [3:0] fifo [$];
  logic [3:0] burst [$];

  // Chip n of symbol sym from the rotation / odd-inversion rule.
  function automatic bit chipOf(int sym, int n);
    int m;
    bit c;
    m = (n - 4 * (sym % 8) + 32) % 32;
    c = BASE[31 - m];
    if (sym >= 8 && (n % 2) == 1) c = !c;
    return c;
  endfunction

  function automatic logic [3:0] lvl(bit c);
    return c ? 4'(LV) : 4'(-LV);
  endfunction

  task automatic checkVec(string tag, logic [11:0] expV);
    logic [11:0] obs;
    obs = {bus.outReadEnable, bus.outI, bus.outQ, bus.outValid, bus.outEndOfSymbol, bus.outBusy};
    checks++;
    assert (obs === expV) else begin
      errors++;
      $error("FAIL %s observed={rd,I,Q,val,eos,busy}=%h expected=%h", tag, obs, expV);
    end
  endtask

  task automatic checkInt(string tag, int obs, int expV);
    checks++;
    assert (obs === expV) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expV);
    end
  endtask

  task automatic checkCount(string tag);
`ifdef ZB_SPREADER_SYMCNT_EN
    checkInt(tag, int'(bus.outSymbolCount), symCountModel);
`else
    if (tag.len() < 0) $display("%s", tag);
`endif
  endtask

  task automatic driveInputs();
    bus.inEmpty = (fifo.size() == 0);
    bus.inData  = (fifo.size() != 0) ? fifo[0] : 4'h0;
  endtask

  // Advance one clock from a falling edge to the next; the FIFO pops on an edge
  // that sees outReadEnable high.
  task automatic step();
    logic pop;
    pop = bus.outReadEnable;
    @(posedge inClock);
    #1;
    if (pop && fifo.size() != 0) void'(fifo.pop_front());
    driveInputs();
    @(negedge inClock);
  endtask

  task automatic waitStart(string name);
    int waitCnt;
    waitCnt = 0;
    while (bus.outReadEnable !== 1'b1 && waitCnt < 8) begin
      step();
      waitCnt++;
    end
    checkInt({name, "_start"}, int'(bus.outReadEnable === 1'b1), 1);
  endtask

  // Queue the burst and check the whole stream: fetch cycle, chips, tail, idle.
  task automatic runBurst(string name);
    int n;
    int rdPulses;
    int eosPulses;
    logic [3:0] eI;
    logic [3:0] eQ;
    logic eRd;
    logic eEos;
    n = burst.size();
    fifo = burst;
    driveInputs();
    waitStart(name);
    checkVec({name, "_fetch"}, {1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1});
    rdPulses  = int'(bus.outReadEnable);
    eosPulses = 0;
    for (int j = 0; j < n; j++) begin
      for (int t = 0; t < SYM_T; t++) begin
        step();
        if (t == 0) symCountModel = (symCountModel + 1) % 65536;
        eI = lvl(chipOf(int'(burst[j]), 2 * (t / (2 * D))));
        if (t >= D) eQ = lvl(chipOf(int'(burst[j]), 2 * ((t - D) / (2 * D)) + 1));
        else        eQ = (j > 0) ? lvl(chipOf(int'(burst[j-1]), 31)) : 4'h0;
        eRd  = (t == SYM_T - 2) && (j < n - 1);
        eEos = (t == SYM_T - 1);
        checkVec($sformatf("%s_sym%0d_t%0d", name, j, t), {eRd, eI, eQ, 1'b1, eEos, 1'b1});
        rdPulses  += int'(bus.outReadEnable);
        eosPulses += int'(bus.outEndOfSymbol);
      end
    end
    for (int k = 0; k < D; k++) begin
      step();
      checkVec($sformatf("%s_tail%0d", name, k),
               {1'b0, 4'h0, lvl(chipOf(int'(burst[n-1]), 31)), 1'b1, 1'b0, 1'b1});
      rdPulses  += int'(bus.outReadEnable);
      eosPulses += int'(bus.outEndOfSymbol);
    end
    step();
    checkVec({name, "_idle"}, 12'h000);
    checkInt({name, "_readPulses"}, rdPulses, n);
    checkInt({name, "_eosPulses"}, eosPulses, n);
    checkCount({name, "_symCount"});
  endtask

  initial begin
    int n;
    bus.inData  = 4'h0;
    bus.inEmpty = 1'b1;
    inReset     = 1'b0;
    repeat (3) @(negedge inClock);
    checkVec("inReset", 12'h000);
    checkCount("inReset_symCount");
    inReset = 1'b1;

    // Empty FIFO: nothing may happen.
    for (int c = 0; c < 100; c++) begin
      step();
      checkVec($sformatf("emptyIdle%0d", c), 12'h000);
    end

    burst.delete();
    burst.push_back(4'h0);
    runBurst("single0");

    burst.delete();
    burst.push_back(4'h1);
    burst.push_back(4'h9);
    runBurst("b2b_1_9");

    burst.delete();
    for (int s = 0; s < 16; s++) burst.push_back(4'(s));
    runBurst("sweep");

    for (int r = 0; r < 3; r++) begin
      burst.delete();
      n = int'($urandom_range(1, 3));
      for (int s = 0; s < n; s++) burst.push_back(4'($urandom_range(0, 15)));
      runBurst($sformatf("rand%0d", r));
      n = int'($urandom_range(0, 5));
      for (int g = 0; g < n; g++) begin
        step();
        checkVec($sformatf("rand%0d_gap%0d", r, g), 12'h000);
      end
    end

    // Reset in the middle of a symbol: outputs drop at once, no tail.
    burst.delete();
    burst.push_back(4'($urandom_range(0, 15)));
    fifo = burst;
    driveInputs();
    waitStart("midReset");
    for (int t = 0; t <= 50; t++) step();
    checkInt("midReset_valid_before", int'(bus.outValid), 1);
    inReset = 1'b0;
    #1;
    checkVec("midReset_now", 12'h000);
    symCountModel = 0;
    checkCount("midReset_symCount");
    @(negedge inClock);
    inReset = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      checkVec($sformatf("postReset_idle%0d", c), 12'h000);
    end

    burst.delete();
    burst.push_back(4'($urandom_range(0, 15)));
    burst.push_back(4'($urandom_range(0, 15)));
    runBurst("postReset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
